// File: rtl/regfile_rv.sv
// regfile_rv: RV32I register file with scoreboard, bypass and registered operands
module regfile_rv #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      read_enable,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      issue_writes_rd,
    input  logic                      wb_enable,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    output logic [XLEN-1:0]           rs1_value,
    output logic [XLEN-1:0]           rs2_value,
    output logic                      operands_valid,
    output logic                      stall,
    output logic [(1<<REG_ADDR_WIDTH)-1:0] busy
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [XLEN-1:0] regs [NREG];
    logic            hit1, hit2, issue;
    logic [XLEN-1:0] rd1, rd2;
    logic [NREG-1:0] clr_mask, set_mask;

    // Hazard detection, same-cycle writeback bypass and scoreboard masks
    always_comb begin
        hit1     = wb_enable && wb_rd == rs1;
        hit2     = wb_enable && wb_rd == rs2;
        stall    = read_enable && ((busy[rs1] && !hit1) || (busy[rs2] && !hit2));
        issue    = read_enable && !stall;
        rd1      = (rs1 == '0) ? '0 : hit1 ? wb_data : regs[rs1];
        rd2      = (rs2 == '0) ? '0 : hit2 ? wb_data : regs[rs2];
        clr_mask = wb_enable ? (NREG'(1) << wb_rd) : '0;
        set_mask = (issue && issue_writes_rd && rd != '0) ? (NREG'(1) << rd) : '0;
    end

    // Register array; x0 is never written so it stays zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_enable && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand capture on accepted issue; set beats clear so a new producer stays pending
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs1_value      <= '0;
            rs2_value      <= '0;
            operands_valid <= 1'b0;
            busy           <= '0;
        end else begin
            operands_valid <= issue;
            if (issue) begin
                rs1_value <= rd1;
                rs2_value <= rd2;
            end
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end
endmodule

// File: tb/tb_regfile_rv.sv
// tb_regfile_rv: directed plus random checks of regfile_rv against an array model
module tb_regfile_rv;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        read_enable = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, wb_rd = '0;
    logic        issue_writes_rd = 1'b0, wb_enable = 1'b0;
    logic [31:0] wb_data = '0;
    logic [31:0] rs1_value, rs2_value, busy;
    logic        operands_valid, stall;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_x [32];
    logic [31:0] m_busy;
    logic [31:0] m_r1, m_r2;
    logic        m_valid;

    regfile_rv dut (
        .clock(clock), .reset_n(reset_n), .read_enable(read_enable),
        .rs1(rs1), .rs2(rs2), .rd(rd), .issue_writes_rd(issue_writes_rd),
        .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .operands_valid(operands_valid), .stall(stall), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        m_busy = '0; m_r1 = '0; m_r2 = '0; m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rs1_value"}, rs1_value, m_r1);
        chk({tag, ".rs2_value"}, rs2_value, m_r2);
        chk({tag, ".valid"}, {31'b0, operands_valid}, {31'b0, m_valid});
        chk({tag, ".busy"}, busy, m_busy);
    endtask

    // One clock cycle: drive, check combinational stall, clock, check registered state
    task automatic cyc(input string tag, input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic wr, input logic we,
                       input logic [4:0] wd, input logic [31:0] wdata);
        logic exp_stall, acc;
        read_enable = re; rs1 = a1; rs2 = a2; rd = d; issue_writes_rd = wr;
        wb_enable = we; wb_rd = wd; wb_data = wdata;
        #1;
        exp_stall = re && ((m_busy[a1] && !(we && wd == a1)) || (m_busy[a2] && !(we && wd == a2)));
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, exp_stall});
        acc = re && !exp_stall;
        if (acc) begin
            m_r1 = (a1 == 0) ? 32'h0 : (we && wd == a1) ? wdata : m_x[a1];
            m_r2 = (a2 == 0) ? 32'h0 : (we && wd == a2) ? wdata : m_x[a2];
        end
        m_valid = acc;
        if (we && wd != 0) m_x[wd] = wdata;
        if (we) m_busy[wd] = 1'b0;
        if (acc && wr && d != 0) m_busy[d] = 1'b1;
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        cyc("rd_x3_x0", 1, 3, 0, 0, 0, 0, 0, 32'h0);
        cyc("idle_hold", 0, 3, 0, 0, 0, 0, 0, 32'h0);
        cyc("wb_x5", 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
        cyc("rd_x5_x5", 1, 5, 5, 0, 0, 0, 0, 32'h0);
        cyc("wb_x0", 0, 0, 0, 0, 0, 1, 0, 32'h1234);
        cyc("rd_x0", 1, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc("set_b7", 1, 0, 0, 7, 1, 0, 0, 32'h0);
        cyc("stall_x7", 1, 7, 0, 0, 0, 0, 0, 32'h0);
        cyc("wb_bypass_x7", 1, 7, 0, 0, 0, 1, 7, 32'h55);
        cyc("wb_x9", 0, 0, 0, 0, 0, 1, 9, 32'h11);
        cyc("bypass_x9", 1, 0, 9, 0, 0, 1, 9, 32'h22);
        cyc("set_b4", 1, 0, 0, 4, 1, 0, 0, 32'h0);
        cyc("collide_b4", 1, 0, 0, 4, 1, 1, 4, 32'hAA);
        cyc("stall_x4", 1, 4, 0, 0, 0, 0, 0, 32'h0);
        cyc("clear_b4", 0, 0, 0, 0, 0, 1, 4, 32'hAA);
        cyc("rd_x4", 1, 4, 2, 0, 0, 0, 0, 32'h0);
        cyc("self_rd", 1, 5, 0, 5, 1, 0, 0, 32'h0);
        cyc("clear_b5", 0, 0, 0, 0, 0, 1, 5, 32'h77);
        cyc("set_b7b", 1, 0, 0, 7, 1, 0, 0, 32'h0);
        cyc("set_b11", 1, 0, 5, 11, 1, 0, 0, 32'h0);
        chk("busy_880", busy, 32'h0000_0880);

        read_enable = 1'b1; rs1 = 7; rs2 = 0; wb_enable = 1'b0; issue_writes_rd = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        chk("async_rst.stall", {31'b0, stall}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc("post_rst_x5", 1, 5, 7, 0, 0, 0, 0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1, a2, d, wd;
            a1 = 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            d  = 5'($urandom_range(0, 7));
            wd = (m_busy != 0 && $urandom_range(0, 1) == 1) ? 5'($clog2(m_busy & -m_busy))
                                                           : 5'($urandom_range(0, 7));
            cyc("rand", 1'($urandom_range(0, 3) != 0), a1, a2, d, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0), wd, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
